// File: rtl/ds_stream_rx.sv
// Down-sampling receiver for a non-stalling memtile stream:
// skips a latency window, keeps beats on a 2-D stride grid, buffers in a FIFO.
module ds_stream_rx #(
  parameter int WIDTH      = 16,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [CNT_W-1:0] cfg_start_skip,
  input  logic [CNT_W-1:0] cfg_range_0,
  input  logic [CNT_W-1:0] cfg_range_1,
  input  logic [CNT_W-1:0] cfg_stride_0,
  input  logic [CNT_W-1:0] cfg_stride_1,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             frame_done,
  output logic             overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic {S_SKIP, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] skip_q, skip_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic [CNT_W-1:0] px_q, px_d;
  logic [CNT_W-1:0] py_q, py_d;

  logic [CNT_W-1:0] s0m1, s1m1;
  logic             run, keep, x_last, y_last;
  logic             push, pop, full, wr_en;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             ovf_q;

  // A skip count already at target means this very beat belongs to RUN.
  always_comb begin
    s0m1    = (cfg_stride_0 == '0) ? '0 : cfg_stride_0 - CNT_W'(1);
    s1m1    = (cfg_stride_1 == '0) ? '0 : cfg_stride_1 - CNT_W'(1);
    run     = (state_q == S_RUN) || (skip_q == cfg_start_skip);
    keep    = (px_q == '0) && (py_q == '0);
    x_last  = (x_q == cfg_range_0);
    y_last  = (y_q == cfg_range_1);
    state_d = state_q;
    skip_d  = skip_q;
    x_d     = x_q;
    y_d     = y_q;
    px_d    = px_q;
    py_d    = py_q;
    if (state_q == S_SKIP) begin
      if (skip_q == cfg_start_skip) begin
        state_d = S_RUN;
      end else if (valid_in) begin
        skip_d = skip_q + CNT_W'(1);
      end
    end
    if (run && valid_in) begin
      if (x_last) begin
        x_d  = '0;
        px_d = '0;
        if (y_last) begin
          y_d  = '0;
          py_d = '0;
        end else begin
          y_d  = y_q + CNT_W'(1);
          py_d = (py_q == s1m1) ? '0 : py_q + CNT_W'(1);
        end
      end else begin
        x_d  = x_q + CNT_W'(1);
        px_d = (px_q == s0m1) ? '0 : px_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_SKIP;
      skip_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
    end else if (flush) begin
      state_q <= S_SKIP;
      skip_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      x_q     <= x_d;
      y_q     <= y_d;
      px_q    <= px_d;
      py_q    <= py_d;
    end
  end

  assign frame_done = run && valid_in && x_last && y_last && !flush && !rst;

  assign valid_out = (cnt_q != '0);
  assign full      = (cnt_q == FULL_CNT);
  assign push      = run && valid_in && keep;
  assign pop       = valid_out && ready_in;
  assign wr_en     = push && (!full || pop);
  assign data_out  = valid_out ? mem_q[rd_q] : '0;
  assign overflow  = ovf_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_q] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_q <= wr_q + AW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
      if (push && full && !pop) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ds_stream_rx.sv
// Self-checking bench for ds_stream_rx: directed scenarios plus
// randomized traffic against an index-arithmetic reference model.
module tb_ds_stream_rx;

  localparam int W  = 16;
  localparam int CW = 16;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [CW-1:0] cfg_start_skip;
  logic [CW-1:0] cfg_range_0;
  logic [CW-1:0] cfg_range_1;
  logic [CW-1:0] cfg_stride_0;
  logic [CW-1:0] cfg_stride_1;
  logic [W-1:0]  data_in;
  logic          valid_in;
  logic [W-1:0]  data_out;
  logic          valid_out;
  logic          ready_in;
  logic          frame_done;
  logic          overflow;

  int errors = 0;
  int checks = 0;
  int got[$];
  int fdv[$];
  int exp_q[$];
  int exp_fd[$];

  ds_stream_rx #(.WIDTH(W), .CNT_W(CW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .cfg_start_skip(cfg_start_skip),
    .cfg_range_0(cfg_range_0), .cfg_range_1(cfg_range_1),
    .cfg_stride_0(cfg_stride_0), .cfg_stride_1(cfg_stride_1),
    .data_in(data_in), .valid_in(valid_in),
    .data_out(data_out), .valid_out(valid_out),
    .ready_in(ready_in), .frame_done(frame_done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    if (!rst && !flush) begin
      if (valid_out && ready_in) got.push_back(int'(data_out));
      if (frame_done) fdv.push_back(int'(data_in));
    end
  end

  // Expected kept data and frame-end data for n consecutive valid beats.
  function automatic void build_exp(int sk, int r0, int r1, int s0,
                                    int s1, int n, int base);
    int n0, tot, e, f, x, y, ss0, ss1;
    exp_q.delete();
    exp_fd.delete();
    n0  = r0 + 1;
    tot = n0 * (r1 + 1);
    ss0 = (s0 == 0) ? 1 : s0;
    ss1 = (s1 == 0) ? 1 : s1;
    for (int i = sk; i < n; i++) begin
      e = i - sk;
      f = e % tot;
      x = f % n0;
      y = f / n0;
      if ((x % ss0 == 0) && (y % ss1 == 0)) exp_q.push_back(base + i);
      if (f == tot - 1) exp_fd.push_back(base + i);
    end
  endfunction

  task automatic set_cfg(int sk, int r0, int r1, int s0, int s1);
    cfg_start_skip = CW'(sk);
    cfg_range_0    = CW'(r0);
    cfg_range_1    = CW'(r1);
    cfg_stride_0   = CW'(s0);
    cfg_stride_1   = CW'(s1);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    flush    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    ready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic feed(int n, int base, bit gap);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 valid_in = 1'b1;
      data_in = W'(base + i);
      if (gap) begin
        @(posedge clk);
        #1 valid_in = 1'b0;
      end
    end
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic test_reset();
    set_cfg(0, 3, 3, 2, 2);
    do_reset();
    checks++;
    if (data_out !== '0)
      $display("FAIL reset_data got=%0h want=0", data_out);
    if (data_out !== '0) errors++;
    checks++;
    if (valid_out !== 1'b0) begin
      $display("FAIL reset_valid got=%b want=0", valid_out);
      errors++;
    end
    checks++;
    if (frame_done !== 1'b0) begin
      $display("FAIL reset_fd got=%b want=0", frame_done);
      errors++;
    end
    checks++;
    if (overflow !== 1'b0) begin
      $display("FAIL reset_ovf got=%b want=0", overflow);
      errors++;
    end
  endtask

  task automatic test_grid(string tag, bit rst_first, bit gap);
    int v;
    set_cfg(0, 3, 3, 2, 2);
    if (rst_first) do_reset();
    ready_in = 1'b1;
    got.delete();
    fdv.delete();
    build_exp(0, 3, 3, 2, 2, 16, 0);
    feed(16, 0, gap);
    checks++;
    if (got.size() != exp_q.size()) begin
      $display("FAIL %s_count got=%0d want=%0d", tag, got.size(), exp_q.size());
      errors++;
    end
    foreach (exp_q[i]) begin
      v = (i < got.size()) ? got[i] : -1;
      checks++;
      if (v !== exp_q[i]) begin
        $display("FAIL %s_data[%0d] got=%0d want=%0d", tag, i, v, exp_q[i]);
        errors++;
      end
    end
    v = (fdv.size() == 1) ? fdv[0] : -1;
    checks++;
    if (fdv.size() != exp_fd.size() || v !== exp_fd[0]) begin
      $display("FAIL %s_frame_done n=%0d beat=%0d want beat %0d",
               tag, fdv.size(), v, exp_fd[0]);
      errors++;
    end
    checks++;
    if (overflow !== 1'b0) begin
      $display("FAIL %s_ovf got=%b want=0", tag, overflow);
      errors++;
    end
  endtask

  task automatic test_latency();
    int v;
    set_cfg(62, 7, 0, 1, 1);
    do_reset();
    got.delete();
    fdv.delete();
    build_exp(62, 7, 0, 1, 1, 70, 0);
    feed(70, 0, 1'b0);
    checks++;
    if (got.size() != exp_q.size()) begin
      $display("FAIL lat_count got=%0d want=%0d", got.size(), exp_q.size());
      errors++;
    end
    foreach (exp_q[i]) begin
      v = (i < got.size()) ? got[i] : -1;
      checks++;
      if (v !== exp_q[i]) begin
        $display("FAIL lat_data[%0d] got=%0d want=%0d", i, v, exp_q[i]);
        errors++;
      end
    end
    v = (fdv.size() == 1) ? fdv[0] : -1;
    checks++;
    if (v !== exp_fd[0]) begin
      $display("FAIL lat_frame_done n=%0d beat=%0d want %0d",
               fdv.size(), v, exp_fd[0]);
      errors++;
    end
  endtask

  task automatic test_overflow();
    int v;
    set_cfg(0, 15, 0, 1, 1);
    do_reset();
    ready_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 valid_in = 1'b1;
      data_in = W'(i);
      @(negedge clk);
      checks++;
      if (overflow !== (i == 5)) begin
        $display("FAIL ovf_beat%0d got=%b want=%b", i, overflow, i == 5);
        errors++;
      end
    end
    @(posedge clk);
    #1 valid_in = 1'b0;
    got.delete();
    ready_in = 1'b1;
    repeat (8) @(posedge clk);
    checks++;
    if (got.size() != D) begin
      $display("FAIL ovf_drain_count got=%0d want=%0d", got.size(), D);
      errors++;
    end
    for (int i = 0; i < D; i++) begin
      v = (i < got.size()) ? got[i] : -1;
      checks++;
      if (v !== i) begin
        $display("FAIL ovf_drain[%0d] got=%0d want=%0d", i, v, i);
        errors++;
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      $display("FAIL ovf_sticky got=%b want=1", overflow);
      errors++;
    end
    // Full FIFO: push and pop in one cycle must not flag overflow.
    do_reset();
    ready_in = 1'b0;
    got.delete();
    for (int i = 0; i < D; i++) begin
      @(posedge clk);
      #1 valid_in = 1'b1;
      data_in = W'(10 + i);
    end
    @(posedge clk);
    #1 data_in = W'(10 + D);
    ready_in = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b1 || data_out !== W'(10)) begin
      $display("FAIL full_pp_head got=%b/%0d want=1/10", valid_out, data_out);
      errors++;
    end
    @(posedge clk);
    #1 valid_in = 1'b0;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0) begin
      $display("FAIL full_pp_ovf got=%b want=0", overflow);
      errors++;
    end
    repeat (8) @(posedge clk);
    for (int i = 0; i <= D; i++) begin
      v = (i < got.size()) ? got[i] : -1;
      checks++;
      if (v !== 10 + i) begin
        $display("FAIL full_pp_data[%0d] got=%0d want=%0d", i, v, 10 + i);
        errors++;
      end
    end
  endtask

  task automatic test_flush();
    int v;
    set_cfg(0, 15, 0, 1, 1);
    do_reset();
    ready_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 valid_in = 1'b1;
      data_in = W'(i);
    end
    @(posedge clk);
    #1 flush = 1'b1;
    data_in = W'(99);
    set_cfg(0, 3, 3, 2, 2);
    @(posedge clk);
    #1 flush = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0 || data_out !== '0) begin
      $display("FAIL flush_empty got=%b/%0d want=0/0", valid_out, data_out);
      errors++;
    end
    checks++;
    if (overflow !== 1'b0) begin
      $display("FAIL flush_ovf got=%b want=0", overflow);
      errors++;
    end
    got.delete();
    fdv.delete();
    build_exp(0, 3, 3, 2, 2, 16, 100);
    feed(16, 100, 1'b0);
    checks++;
    if (got.size() != exp_q.size()) begin
      $display("FAIL flush_count got=%0d want=%0d", got.size(), exp_q.size());
      errors++;
    end
    foreach (exp_q[i]) begin
      v = (i < got.size()) ? got[i] : -1;
      checks++;
      if (v !== exp_q[i]) begin
        $display("FAIL flush_data[%0d] got=%0d want=%0d", i, v, exp_q[i]);
        errors++;
      end
    end
  endtask

  task automatic test_async_reset();
    set_cfg(0, 3, 3, 2, 2);
    do_reset();
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 valid_in = 1'b1;
      data_in = W'(i);
    end
    @(posedge clk);
    #1 valid_in = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b1) begin
      $display("FAIL arst_pre got=%b want=1", valid_out);
      errors++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (valid_out !== 1'b0 || data_out !== '0) begin
      $display("FAIL arst_out got=%b/%0d want=0/0", valid_out, data_out);
      errors++;
    end
    checks++;
    if (frame_done !== 1'b0 || overflow !== 1'b0) begin
      $display("FAIL arst_flags got=%b/%b want=0/0", frame_done, overflow);
      errors++;
    end
    ready_in = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    test_grid("arst_grid", 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int sk, r0, r1, s0, s1, n0, tot, e, f, ss0, ss1, bi;
    bit keep [0:299];
    bit fdb [0:299];
    logic [W-1:0] mq[$];
    bit ovf, v, rdy, pop, fd_exp;
    for (int it = 0; it < 6; it++) begin
      sk = $urandom_range(0, 5);
      r0 = $urandom_range(0, 4);
      r1 = $urandom_range(0, 3);
      s0 = $urandom_range(0, 3);
      s1 = $urandom_range(0, 3);
      set_cfg(sk, r0, r1, s0, s1);
      do_reset();
      n0  = r0 + 1;
      tot = n0 * (r1 + 1);
      ss0 = (s0 == 0) ? 1 : s0;
      ss1 = (s1 == 0) ? 1 : s1;
      for (int b = 0; b < 300; b++) begin
        e = b - sk;
        f = (e < 0) ? 0 : e % tot;
        keep[b] = (e >= 0) && ((f % n0) % ss0 == 0) && ((f / n0) % ss1 == 0);
        fdb[b]  = (e >= 0) && (f == tot - 1);
      end
      mq.delete();
      ovf = 1'b0;
      bi  = 0;
      for (int c = 0; c < 250; c++) begin
        @(posedge clk);
        v   = ($urandom_range(0, 3) != 0);
        rdy = (it % 2 == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
        #1 valid_in = v;
        ready_in = rdy;
        data_in  = W'($urandom);
        @(negedge clk);
        fd_exp = v && fdb[bi];
        checks++;
        if (valid_out !== (mq.size() > 0)) begin
          $display("FAIL rnd%0d_valid c=%0d got=%b want=%b",
                   it, c, valid_out, mq.size() > 0);
          errors++;
        end
        if (mq.size() > 0) begin
          checks++;
          if (data_out !== mq[0]) begin
            $display("FAIL rnd%0d_data c=%0d got=%0h want=%0h",
                     it, c, data_out, mq[0]);
            errors++;
          end
        end
        checks++;
        if (overflow !== ovf) begin
          $display("FAIL rnd%0d_ovf c=%0d got=%b want=%b", it, c, overflow, ovf);
          errors++;
        end
        checks++;
        if (frame_done !== fd_exp) begin
          $display("FAIL rnd%0d_fd c=%0d got=%b want=%b",
                   it, c, frame_done, fd_exp);
          errors++;
        end
        pop = rdy && (mq.size() > 0);
        if (pop) void'(mq.pop_front());
        if (v && keep[bi]) begin
          if (mq.size() < D) mq.push_back(data_in);
          else ovf = 1'b1;
        end
        if (v) bi++;
      end
      @(posedge clk);
      #1 valid_in = 1'b0;
    end
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    ready_in = 1'b1;
    set_cfg(0, 0, 0, 1, 1);
    test_reset();
    test_grid("grid", 1'b1, 1'b0);
    test_latency();
    test_grid("gap", 1'b1, 1'b1);
    test_overflow();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
